// File: rtl/c_phase_seq_pkg.sv
// Shared types and constants for the VPE-array phase sequencer.
// Holds the state enum, RESULT codes and the state-to-phase decode.
package c_phase_seq_pkg;

    localparam int unsigned N_VPE_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRAM = 3'd1,
        ST_VAR  = 3'd2,
        ST_PROC = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_SAT   = 2'b01;
    localparam logic [1:0] RES_LIMIT = 2'b10;

    // Mode lines presented to the clock/enable driver.
    typedef struct packed {
        logic sram_st;
        logic var_st;
        logic proc_st;
    } phase_t;

    function automatic phase_t phase_decode(input state_e s);
        phase_t p;
        p.sram_st = (s == ST_SRAM);
        p.var_st  = (s == ST_VAR);
        p.proc_st = (s == ST_PROC);
        return p;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/c_phase_cnt.sv
// Loadable down counter with wrap; shared by the VAR dwell count and the PROC phase count.
// tc_c flags the last count value (zero); an enabled count at zero reloads WRAP_VAL.
module c_phase_cnt
    #(
        parameter int unsigned CNT_W    = 4,
        parameter int unsigned WRAP_VAL = 11
    )
    (
        input  logic             clk,
        input  logic             rst,
        input  logic             load,
        input  logic [CNT_W-1:0] load_val,
        input  logic             en,
        output logic             tc_c
    );

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_W'(WRAP_VAL);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/c_phase_seq.sv
// Phase sequencer for the SAT accelerator VPE array: clause-SRAM load, variable init,
// then processing rounds until SAT or the round limit; drives the enable driver's mode lines.
module c_phase_seq
    import c_phase_seq_pkg::*;
    #(
        parameter int unsigned N_VPE   = N_VPE_DEF,
        parameter int unsigned ADDR_W  = 10,
        parameter int unsigned VAR_CYC = 4,
        parameter int unsigned ROUND_W = 16
    )
    (
        input  logic               CLK,
        input  logic               RESET,
        input  logic               START,
        input  logic [ADDR_W-1:0]  LOAD_LEN,
        input  logic [ROUND_W-1:0] MAX_ROUNDS,
        input  logic               SHUFFLE_EN,
        input  logic               LOAD_VALID,
        output logic               LOAD_READY,
        output logic               SRAM_WE,
        output logic [ADDR_W-1:0]  SRAM_ADDR,
        input  logic               SAT_FLAG,
        output logic               SRAM_STATE,
        output logic               VAR_STATE,
        output logic               PROC_STATE,
        output logic               SHUFFLE,
        output logic [ROUND_W-1:0] ROUND_CNT,
        output logic               DONE,
        output logic [1:0]         RESULT,
        output logic               BUSY
    );

    localparam int unsigned CNT_W = $clog2(max_u(max_u(N_VPE, VAR_CYC), 2));

    state_e             state_q,      state_d;
    logic [ADDR_W-1:0]  sram_addr_q,  sram_addr_d;
    logic [ADDR_W-1:0]  load_len_q,   load_len_d;
    logic [ROUND_W-1:0] max_rounds_q, max_rounds_d;
    logic               shuffle_en_q, shuffle_en_d;
    logic               shuffle_q,    shuffle_d;
    logic [ROUND_W-1:0] round_cnt_q,  round_cnt_d;
    logic [1:0]         result_q,     result_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_en;
    logic               cnt_tc_c;
    logic               sram_we_c;
    logic [ROUND_W-1:0] round_inc_c;
    phase_t             phase_c;

    assign phase_c   = phase_decode(state_q);
    assign sram_we_c = LOAD_VALID & phase_c.sram_st;

    // Round count saturates so an unbounded run never wraps back to zero.
    assign round_inc_c = (&round_cnt_q) ? round_cnt_q : round_cnt_q + ROUND_W'(1);

    c_phase_cnt #(
        .CNT_W    (CNT_W),
        .WRAP_VAL (N_VPE - 1)
    ) u_phase_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .tc_c     (cnt_tc_c)
    );

    always_comb begin
        state_d      = state_q;
        sram_addr_d  = sram_addr_q;
        load_len_d   = load_len_q;
        max_rounds_d = max_rounds_q;
        shuffle_en_d = shuffle_en_q;
        shuffle_d    = shuffle_q;
        round_cnt_d  = round_cnt_q;
        result_d     = result_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    load_len_d   = LOAD_LEN;
                    max_rounds_d = MAX_ROUNDS;
                    shuffle_en_d = SHUFFLE_EN;
                    sram_addr_d  = '0;
                    round_cnt_d  = '0;
                    shuffle_d    = 1'b0;
                    result_d     = RES_NONE;
                    if (LOAD_LEN == '0) begin
                        state_d      = ST_VAR;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(VAR_CYC - 1);
                    end else begin
                        state_d = ST_SRAM;
                    end
                end
            end

            ST_SRAM: begin
                if (sram_we_c) begin
                    sram_addr_d = sram_addr_q + ADDR_W'(1);
                    if (sram_addr_q == load_len_q - ADDR_W'(1)) begin
                        state_d      = ST_VAR;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(VAR_CYC - 1);
                    end
                end
            end

            ST_VAR: begin
                cnt_en = 1'b1;
                if (cnt_tc_c) begin
                    state_d      = ST_PROC;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(N_VPE - 1);
                end
            end

            ST_PROC: begin
                cnt_en = 1'b1;
                // SAT takes priority over a coinciding wrap and suppresses its round update.
                if (SAT_FLAG) begin
                    state_d  = ST_DONE;
                    result_d = RES_SAT;
                end else if (cnt_tc_c) begin
                    round_cnt_d = round_inc_c;
                    shuffle_d   = shuffle_q ^ shuffle_en_q;
                    if ((max_rounds_q != '0) && (round_inc_c == max_rounds_q)) begin
                        state_d  = ST_DONE;
                        result_d = RES_LIMIT;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            sram_addr_q  <= '0;
            load_len_q   <= '0;
            max_rounds_q <= '0;
            shuffle_en_q <= 1'b0;
            shuffle_q    <= 1'b0;
            round_cnt_q  <= '0;
            result_q     <= RES_NONE;
        end else begin
            state_q      <= state_d;
            sram_addr_q  <= sram_addr_d;
            load_len_q   <= load_len_d;
            max_rounds_q <= max_rounds_d;
            shuffle_en_q <= shuffle_en_d;
            shuffle_q    <= shuffle_d;
            round_cnt_q  <= round_cnt_d;
            result_q     <= result_d;
        end
    end

    assign LOAD_READY = phase_c.sram_st;
    assign SRAM_WE    = sram_we_c;
    assign SRAM_ADDR  = sram_addr_q;
    assign SRAM_STATE = phase_c.sram_st;
    assign VAR_STATE  = phase_c.var_st;
    assign PROC_STATE = phase_c.proc_st;
    assign SHUFFLE    = shuffle_q;
    assign ROUND_CNT  = round_cnt_q;
    assign DONE       = (state_q == ST_DONE);
    assign RESULT     = result_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_c_phase_seq.sv
// Directed bench for c_phase_seq: a table of whole-run scenarios plus hand-written
// sequences for VALID gaps and mid-run reset.
module tb_c_phase_seq;

    localparam int unsigned N_VPE   = 12;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned VAR_CYC = 4;
    localparam int unsigned ROUND_W = 16;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               START;
    logic [ADDR_W-1:0]  LOAD_LEN;
    logic [ROUND_W-1:0] MAX_ROUNDS;
    logic               SHUFFLE_EN;
    logic               LOAD_VALID;
    logic               LOAD_READY;
    logic               SRAM_WE;
    logic [ADDR_W-1:0]  SRAM_ADDR;
    logic               SAT_FLAG;
    logic               SRAM_STATE;
    logic               VAR_STATE;
    logic               PROC_STATE;
    logic               SHUFFLE;
    logic [ROUND_W-1:0] ROUND_CNT;
    logic               DONE;
    logic [1:0]         RESULT;
    logic               BUSY;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    c_phase_seq #(
        .N_VPE   (N_VPE),
        .ADDR_W  (ADDR_W),
        .VAR_CYC (VAR_CYC),
        .ROUND_W (ROUND_W)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .LOAD_LEN   (LOAD_LEN),
        .MAX_ROUNDS (MAX_ROUNDS),
        .SHUFFLE_EN (SHUFFLE_EN),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .SRAM_WE    (SRAM_WE),
        .SRAM_ADDR  (SRAM_ADDR),
        .SAT_FLAG   (SAT_FLAG),
        .SRAM_STATE (SRAM_STATE),
        .VAR_STATE  (VAR_STATE),
        .PROC_STATE (PROC_STATE),
        .SHUFFLE    (SHUFFLE),
        .ROUND_CNT  (ROUND_CNT),
        .DONE       (DONE),
        .RESULT     (RESULT),
        .BUSY       (BUSY)
    );

    typedef struct {
        int         load_len;
        int         max_rounds;
        bit         sh_en;
        int         sat_cyc;    // PROC cycle (1-based) with SAT_FLAG high, 0 = never
        int         start_cyc;  // PROC cycle with a stray START pulse, 0 = none
        int         exp_proc;
        logic [1:0] exp_res;
        int         exp_round;
        bit         exp_shuf;
    } scn_t;

    scn_t scn[6];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_sram_st"}, 32'(SRAM_STATE), 0);
        chk({tag, "_var_st"},  32'(VAR_STATE), 0);
        chk({tag, "_proc_st"}, 32'(PROC_STATE), 0);
        chk({tag, "_ready"},   32'(LOAD_READY), 0);
        chk({tag, "_we"},      32'(SRAM_WE), 0);
        chk({tag, "_addr"},    32'(SRAM_ADDR), 0);
        chk({tag, "_shuffle"}, 32'(SHUFFLE), 0);
        chk({tag, "_round"},   32'(ROUND_CNT), 0);
        chk({tag, "_done"},    32'(DONE), 0);
        chk({tag, "_result"},  32'(RESULT), 0);
        chk({tag, "_busy"},    32'(BUSY), 0);
    endtask

    // Drives one full run from START and checks every phase boundary against the record.
    task automatic run_scn(input scn_t s);
        int lat;
        int p;
        int rnd;
        LOAD_LEN   = ADDR_W'(s.load_len);
        MAX_ROUNDS = ROUND_W'(s.max_rounds);
        SHUFFLE_EN = s.sh_en;
        LOAD_VALID = 1'b1;
        START      = 1'b1;
        step();
        START = 1'b0;
        lat   = 1;
        chk("start_sram_st", 32'(SRAM_STATE), 32'(s.load_len > 0));
        chk("start_var_st",  32'(VAR_STATE),  32'(s.load_len == 0));
        chk("start_result",  32'(RESULT), 0);
        for (int i = 0; i < s.load_len; i++) begin
            chk("load_sram_st", 32'(SRAM_STATE), 1);
            chk("load_we",      32'(SRAM_WE), 1);
            chk("load_addr",    32'(SRAM_ADDR), 32'(i));
            step();
            lat++;
        end
        for (int i = 0; i < int'(VAR_CYC); i++) begin
            chk("var_st",      32'(VAR_STATE), 1);
            chk("var_sram_st", 32'(SRAM_STATE), 0);
            chk("var_we",      32'(SRAM_WE), 0);
            step();
            lat++;
        end
        LOAD_VALID = 1'b0;
        chk("proc_entry", 32'(PROC_STATE), 1);
        p = 0;
        while (PROC_STATE && p < 2000) begin
            p++;
            rnd = (p - 1) / int'(N_VPE);
            chk("proc_round",   32'(ROUND_CNT), 32'(rnd));
            chk("proc_shuffle", 32'(SHUFFLE), 32'(s.sh_en && (rnd % 2 == 1)));
            chk("proc_busy",    32'(BUSY), 1);
            START    = (p == s.start_cyc);
            SAT_FLAG = (p == s.sat_cyc);
            step();
            lat++;
        end
        START    = 1'b0;
        SAT_FLAG = 1'b0;
        chk("proc_cycles", 32'(p), 32'(s.exp_proc));
        chk("latency",     32'(lat), 32'(s.load_len + int'(VAR_CYC) + s.exp_proc + 1));
        chk("done_pulse",  32'(DONE), 1);
        chk("done_busy",   32'(BUSY), 1);
        chk("done_result", 32'(RESULT), 32'(s.exp_res));
        chk("done_round",  32'(ROUND_CNT), 32'(s.exp_round));
        chk("done_shuf",   32'(SHUFFLE), 32'(s.exp_shuf));
        step();
        chk("idle_done",    32'(DONE), 0);
        chk("idle_busy",    32'(BUSY), 0);
        chk("idle_result",  32'(RESULT), 32'(s.exp_res));
        chk("idle_shuf",    32'(SHUFFLE), 32'(s.exp_shuf));
    endtask

    initial begin
        //         len max sh sat st  proc res    rnd shuf
        scn[0] = '{3,  2,  0, 0,  0,  24,  2'b10, 2,  0};
        scn[1] = '{1,  3,  1, 0,  0,  36,  2'b10, 3,  1};
        scn[2] = '{0,  0,  0, 5,  3,  5,   2'b01, 0,  0};
        scn[3] = '{0,  1,  0, 12, 0,  12,  2'b01, 0,  0};
        scn[4] = '{2,  0,  1, 30, 0,  30,  2'b01, 2,  0};
        scn[5] = '{0,  0,  0, 1,  0,  1,   2'b01, 0,  0};

        RESET      = 1'b1;
        START      = 1'b0;
        LOAD_LEN   = '0;
        MAX_ROUNDS = '0;
        SHUFFLE_EN = 1'b0;
        LOAD_VALID = 1'b0;
        SAT_FLAG   = 1'b0;
        step();
        step();
        RESET = 1'b0;
        check_idle_zero("por");

        // SAT_FLAG outside PROC must not disturb IDLE.
        SAT_FLAG = 1'b1;
        step();
        SAT_FLAG = 1'b0;
        chk("idle_sat_busy", 32'(BUSY), 0);
        chk("idle_sat_res",  32'(RESULT), 0);

        for (int k = 0; k < 6; k++) begin
            run_scn(scn[k]);
        end

        // VALID gaps during load: writes only where VALID is high.
        begin
            bit pat [4];
            pat = '{1'b1, 1'b0, 1'b0, 1'b1};
            LOAD_LEN   = ADDR_W'(2);
            MAX_ROUNDS = '0;
            SHUFFLE_EN = 1'b0;
            START      = 1'b1;
            step();
            START = 1'b0;
            for (int i = 0; i < 4; i++) begin
                LOAD_VALID = pat[i];
                #1;
                chk("gap_sram_st", 32'(SRAM_STATE), 1);
                chk("gap_we",      32'(SRAM_WE), 32'(pat[i]));
                chk("gap_addr",    32'(SRAM_ADDR), (i == 0) ? 0 : 1);
                step();
            end
            LOAD_VALID = 1'b0;
            chk("gap_var_st",   32'(VAR_STATE), 1);
            chk("gap_sram_off", 32'(SRAM_STATE), 0);
            chk("gap_addr_end", 32'(SRAM_ADDR), 2);
            for (int i = 0; i < 50 && !PROC_STATE; i++) step();
            chk("gap_proc", 32'(PROC_STATE), 1);
            SAT_FLAG = 1'b1;
            step();
            SAT_FLAG = 1'b0;
            chk("gap_done", 32'(DONE), 1);
            chk("gap_res",  32'(RESULT), 1);
            step();
        end

        // Reset mid-PROC after one round with shuffle set.
        LOAD_LEN   = ADDR_W'(1);
        MAX_ROUNDS = '0;
        SHUFFLE_EN = 1'b1;
        LOAD_VALID = 1'b1;
        START      = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 100 && ROUND_CNT != ROUND_W'(1); i++) step();
        LOAD_VALID = 1'b0;
        chk("rst_pre_round", 32'(ROUND_CNT), 1);
        chk("rst_pre_shuf",  32'(SHUFFLE), 1);
        chk("rst_pre_proc",  32'(PROC_STATE), 1);
        chk("rst_pre_addr",  32'(SRAM_ADDR), 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check_idle_zero("midrst");
        run_scn(scn[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
